// File: rtl/data_reg_bank_pkg.sv
// Shared types and default sizing for the DataRegBank write-port arbiter.
package data_reg_bank_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned N_UNITS_DEF = 4;
  localparam int unsigned ADDR_W_DEF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_SYNC  = 2'd2,
    ST_CLEAR = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping to 0.
module rr_arbiter #(
  parameter int unsigned N_UNITS = 4,
  parameter int unsigned ADDR_W  = 2
) (
  input  logic [N_UNITS-1:0] req,
  input  logic [ADDR_W-1:0]  ptr,
  output logic               grant_valid,
  output logic [ADDR_W-1:0]  grant_idx
);

  always_comb begin
    int unsigned idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < N_UNITS; k++) begin
      idx = (32'(ptr) + k) % N_UNITS;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = ADDR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/data_reg_bank_arbiter.sv
// Shares the DataRegBank write port among the units and sequences writeAll/clear.
// Every bank-side output is driven straight from a register.
module data_reg_bank_arbiter
  import data_reg_bank_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned N_UNITS = N_UNITS_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_UNITS-1:0]        unit_req,
  input  logic [N_UNITS*DATA_W-1:0] unit_data,
  output logic [N_UNITS-1:0]        unit_ack,
  input  logic                      sync_req,
  output logic                      sync_ack,
  input  logic                      clr_req,
  output logic                      clr_ack,
  output logic [DATA_W-1:0]         bank_data,
  output logic [ADDR_W-1:0]         bank_addr,
  output logic                      bank_write_addr,
  output logic                      bank_write_all,
  output logic                      bank_clr,
  output logic                      busy
);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                 sync_owed_q, sync_owed_d;
  logic [DATA_W-1:0]    bank_data_q, bank_data_d;
  logic [ADDR_W-1:0]    bank_addr_q, bank_addr_d;
  logic [N_UNITS-1:0]   unit_ack_q, unit_ack_d;
  logic                 write_addr_q, write_addr_d;
  logic                 write_all_q, write_all_d;
  logic                 clr_q, clr_d;
  logic                 busy_q, busy_d;

  logic                 grant_valid;
  logic [ADDR_W-1:0]    grant_idx;
  logic [DATA_W-1:0]    win_data;

  rr_arbiter #(
    .N_UNITS (N_UNITS),
    .ADDR_W  (ADDR_W)
  ) u_rr (
    .req         (unit_req),
    .ptr         (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign win_data = unit_data[32'(grant_idx)*DATA_W +: DATA_W];

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    sync_owed_d  = sync_owed_q;
    bank_data_d  = bank_data_q;
    bank_addr_d  = bank_addr_q;
    unit_ack_d   = '0;
    write_addr_d = 1'b0;
    write_all_d  = 1'b0;
    clr_d        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Strobes are registered, so they are set on the edge that enters the op state.
        if (clr_req) begin
          state_d = ST_CLEAR;
          clr_d   = 1'b1;
        end else if (sync_req && !sync_owed_q) begin
          state_d     = ST_SYNC;
          write_all_d = 1'b1;
        end else if (grant_valid) begin
          state_d      = ST_WRITE;
          write_addr_d = 1'b1;
          bank_addr_d  = grant_idx;
          bank_data_d  = win_data;
          unit_ack_d   = N_UNITS'(1) << grant_idx;
        end else if (sync_req) begin
          state_d     = ST_SYNC;
          write_all_d = 1'b1;
        end
      end
      ST_WRITE: begin
        state_d     = ST_IDLE;
        rr_ptr_d    = (bank_addr_q == ADDR_W'(N_UNITS-1)) ? '0 : bank_addr_q + 1'b1;
        sync_owed_d = 1'b0;
      end
      ST_SYNC: begin
        state_d     = ST_IDLE;
        sync_owed_d = 1'b1;
      end
      ST_CLEAR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      sync_owed_q  <= 1'b0;
      bank_data_q  <= '0;
      bank_addr_q  <= '0;
      unit_ack_q   <= '0;
      write_addr_q <= 1'b0;
      write_all_q  <= 1'b0;
      clr_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      sync_owed_q  <= sync_owed_d;
      bank_data_q  <= bank_data_d;
      bank_addr_q  <= bank_addr_d;
      unit_ack_q   <= unit_ack_d;
      write_addr_q <= write_addr_d;
      write_all_q  <= write_all_d;
      clr_q        <= clr_d;
      busy_q       <= busy_d;
    end
  end

  assign unit_ack        = unit_ack_q;
  assign sync_ack        = write_all_q;
  assign clr_ack         = clr_q;
  assign bank_data       = bank_data_q;
  assign bank_addr       = bank_addr_q;
  assign bank_write_addr = write_addr_q;
  assign bank_write_all  = write_all_q;
  assign bank_clr        = clr_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_data_reg_bank_arbiter.sv
// Directed bench for data_reg_bank_arbiter: reset, writes, fairness, sync/clear ordering.
module tb_data_reg_bank_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   unit_req;
  logic [127:0] unit_data;
  logic [3:0]   unit_ack;
  logic         sync_req, sync_ack, clr_req, clr_ack;
  logic [31:0]  bank_data;
  logic [1:0]   bank_addr;
  logic         bank_write_addr, bank_write_all, bank_clr, busy;

  int tests = 0;
  int fails = 0;
  logic started = 1'b0;

  localparam logic [31:0] W0 = 32'h0F0F_0000;
  localparam logic [31:0] W1 = 32'h1111_0001;
  localparam logic [31:0] W2 = 32'hDEAD_BEEF;
  localparam logic [31:0] W3 = 32'h3333_0003;

  data_reg_bank_arbiter #(
    .DATA_W  (32),
    .N_UNITS (4),
    .ADDR_W  (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .unit_req        (unit_req),
    .unit_data       (unit_data),
    .unit_ack        (unit_ack),
    .sync_req        (sync_req),
    .sync_ack        (sync_ack),
    .clr_req         (clr_req),
    .clr_ack         (clr_ack),
    .bank_data       (bank_data),
    .bank_addr       (bank_addr),
    .bank_write_addr (bank_write_addr),
    .bank_write_all  (bank_write_all),
    .bank_clr        (bank_clr),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Strobe exclusivity and ack/strobe coincidence, checked away from the active edge.
  always @(negedge clk) begin
    if (started && !reset) begin
      tests++;
      assert ($onehot0({bank_write_addr, bank_write_all, bank_clr}) && $onehot0(unit_ack)
              && (sync_ack === bank_write_all) && (clr_ack === bank_clr))
      else begin
        fails++;
        $error("FAIL excl: strobes=%b ack=%b sync_ack=%b clr_ack=%b required onehot0/coincident",
               {bank_write_addr, bank_write_all, bank_clr}, unit_ack, sync_ack, clr_ack);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Snapshot layout: ack[4] wa wall clr sack cack busy addr[2] data[32]
  task automatic expect_st(input string tag, input logic [3:0] ack, input logic wa,
                           input logic wall, input logic clr, input logic [1:0] addr,
                           input logic [31:0] data);
    logic [43:0] obs, exp;
    obs = {unit_ack, bank_write_addr, bank_write_all, bank_clr, sync_ack, clr_ack, busy,
           bank_addr, bank_data};
    exp = {ack, wa, wall, clr, wall, clr, (wa | wall | clr), addr, data};
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_write(input string tag, input int idx, input logic [31:0] data);
    expect_st(tag, 4'(1 << idx), 1'b1, 1'b0, 1'b0, 2'(idx), data);
  endtask

  initial begin
    reset     = 1'b1;
    unit_req  = 4'b1111;
    sync_req  = 1'b1;
    clr_req   = 1'b1;
    unit_data = {W3, 32'h2222_0002, W1, W0};

    // Reset held with every request high.
    tick();
    started = 1'b1;
    tick();
    expect_st("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);

    reset    = 1'b0;
    sync_req = 1'b0;
    clr_req  = 1'b0;
    tick();
    expect_write("first_op_w0", 0, W0);
    unit_req = 4'b0000;
    tick();
    expect_st("idle_hold", 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, W0);

    // Single write from unit 2.
    unit_data[64 +: 32] = W2;
    unit_req = 4'b0100;
    tick();
    expect_write("single_w2", 2, W2);
    unit_req = 4'b0000;
    tick();
    expect_st("single_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, W2);

    // rr_ptr is now 3: unit 3 beats unit 0.
    unit_req = 4'b1001;
    tick();
    expect_write("ptr3_w3", 3, W3);
    unit_req = 4'b0000;
    tick();
    expect_st("ptr3_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, W3);

    // Fairness: 0,1,2,3 then re-raised unit 0.
    unit_req = 4'b1111;
    tick();
    expect_write("rr_w0", 0, W0);
    unit_req = 4'b1110;
    tick();
    expect_st("rr_gap0", 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, W0);
    tick();
    expect_write("rr_w1", 1, W1);
    unit_req = 4'b1101;
    tick();
    tick();
    expect_write("rr_w2", 2, W2);
    unit_req = 4'b1001;
    tick();
    tick();
    expect_write("rr_w3", 3, W3);
    unit_req = 4'b0001;
    tick();
    tick();
    expect_write("rr_w0_again", 0, W0);
    unit_req = 4'b0000;
    tick();
    expect_st("rr_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, W0);

    // Sync vs writes: SYNC, WRITE(0), SYNC.
    sync_req = 1'b1;
    unit_req = 4'b0001;
    tick();
    expect_st("sync1", 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, W0);
    tick();
    expect_st("sync1_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, W0);
    tick();
    expect_write("sync_owed_w0", 0, W0);
    unit_req = 4'b0000;
    tick();
    tick();
    expect_st("sync2", 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, W0);
    sync_req = 1'b0;
    tick();
    expect_st("sync2_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, W0);

    // Write to clear sync_owed before the priority test.
    unit_req = 4'b0010;
    tick();
    expect_write("pre_clr_w1", 1, W1);
    unit_req = 4'b0000;
    tick();

    // Clear priority: CLEAR, SYNC, WRITE(3).
    clr_req  = 1'b1;
    sync_req = 1'b1;
    unit_req = 4'b1000;
    tick();
    expect_st("clear", 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, W1);
    clr_req = 1'b0;
    tick();
    tick();
    expect_st("clr_then_sync", 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, W1);
    sync_req = 1'b0;
    tick();
    tick();
    expect_write("clr_then_w3", 3, W3);
    unit_req = 4'b0000;
    tick();
    expect_st("clr_seq_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, W3);

    // Reset during a WRITE; rr_ptr returns to 0.
    unit_req = 4'b0010;
    tick();
    expect_write("pre_rst_w1", 1, W1);
    unit_req = 4'b0000;
    tick();
    unit_req = 4'b1010;
    tick();
    expect_write("pre_rst_w3", 3, W3);
    reset = 1'b1;
    tick();
    expect_st("mid_reset", 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
    reset = 1'b0;
    tick();
    expect_write("post_rst_w1", 1, W1);
    unit_req = 4'b0000;
    tick();
    expect_st("final_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, W1);

    started = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
